// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared types and constants for the sprite draw scheduler: FSM states,
// coordinate/colour widths and the named framebuffer colours.
package sprite_draw_scheduler_pkg;

  localparam int COORD_W = 7;
  localparam int COL_W   = 3;
  localparam int ID_W    = 3;

  localparam logic [COL_W-1:0] BLACK = 3'b000;
  localparam logic [COL_W-1:0] WHITE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ERASE = 3'd2,
    S_DRAW  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Bundle of the mover-side request bus and the framebuffer write port.
// The scheduler takes the slave side; movers / the bench take the master side.
interface sprite_draw_scheduler_if #(
  parameter int N_REQ = 4
);
  import sprite_draw_scheduler_pkg::*;

  logic [N_REQ-1:0]         req;
  logic [COORD_W*N_REQ-1:0] req_x;
  logic [COORD_W*N_REQ-1:0] req_y;
  logic [COORD_W*N_REQ-1:0] req_old_x;
  logic [COORD_W*N_REQ-1:0] req_old_y;
  logic [COL_W*N_REQ-1:0]   req_colour;
  logic [COL_W-1:0]         bg_colour;
  logic [N_REQ-1:0]         ack;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;
  logic                     plot;
  logic [COORD_W-1:0]       x_out;
  logic [COORD_W-1:0]       y_out;
  logic [COL_W-1:0]         c_out;

  modport master (
    output req, req_x, req_y, req_old_x, req_old_y, req_colour, bg_colour,
    input  ack, busy, grant_id, plot, x_out, y_out, c_out
  );

  modport slave (
    input  req, req_x, req_y, req_old_x, req_old_y, req_colour, bg_colour,
    output ack, busy, grant_id, plot, x_out, y_out, c_out
  );

endinterface

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request after the last granted
// index (wrapping). The pointer only moves when a grant is actually taken.
module sprite_draw_scheduler_rr_arbiter
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             valid
);

  localparam int CAND_W = ID_W + 1;

  logic [ID_W-1:0]   pointer;
  logic [CAND_W-1:0] cand;

  // Scan candidates pointer+1 .. pointer+N_REQ (mod N_REQ), first set one wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, pointer} + CAND_W'(k);
      if (cand >= CAND_W'(N_REQ)) cand = cand - CAND_W'(N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (!valid && req[i] && (cand == CAND_W'(i))) begin
          valid     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

  // Pointer starts at the last mover so mover 0 has top priority after reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pointer <= ID_W'(N_REQ - 1);
    end else if (enable && valid) begin
      pointer <= grant_idx;
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares the framebuffer write port between N_REQ sprite movers. Each granted
// job erases the mover's old block in bg_colour (skipped if it has not moved),
// then draws the new block, then pulses ack to that mover.
// All outputs are registered; the output stage is loaded from the next state so
// plot/x/y/colour line up with the ERASE/DRAW state cycles.
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int SPR_LOG2 = 2
) (
  input logic                    clk,
  input logic                    resetn,
  sprite_draw_scheduler_if.slave bus
);

  localparam int OFF_W = 2 * SPR_LOG2;
  localparam int SUM_W = COORD_W + 1;
  localparam logic [OFF_W-1:0] OFF_LAST = '1;

  state_t state, state_next;

  logic [N_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;
  logic               arb_enable;

  logic [ID_W-1:0]    grant_id_q;
  logic [N_REQ-1:0]   grant_mask;
  logic [OFF_W-1:0]   off;

  logic [COORD_W-1:0] sel_x, sel_y, sel_ox, sel_oy;
  logic [COL_W-1:0]   sel_col;
  logic [COORD_W-1:0] lat_x, lat_y, lat_ox, lat_oy;
  logic [COL_W-1:0]   lat_col;
  logic               same_pos;

  logic [OFF_W-1:0]   pix_off;
  logic [COORD_W-1:0] base_x, base_y;
  logic [COL_W-1:0]   colour;
  logic [SUM_W-1:0]   sum_x, sum_y;

  logic               plot_d, busy_d;
  logic [COORD_W-1:0] x_d, y_d;
  logic [COL_W-1:0]   c_d;
  logic [N_REQ-1:0]   ack_d;

  logic               plot_q, busy_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COL_W-1:0]   c_q;
  logic [N_REQ-1:0]   ack_q;

  assign arb_enable = (state == S_IDLE);

  sprite_draw_scheduler_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .req      (bus.req),
    .enable   (arb_enable),
    .grant    (arb_grant),
    .grant_idx(arb_idx),
    .valid    (arb_valid)
  );

  // Select the granted mover's coordinates and colour from the packed buses
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_ox  = '0;
    sel_oy  = '0;
    sel_col = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_x   = bus.req_x[COORD_W*i +: COORD_W];
        sel_y   = bus.req_y[COORD_W*i +: COORD_W];
        sel_ox  = bus.req_old_x[COORD_W*i +: COORD_W];
        sel_oy  = bus.req_old_y[COORD_W*i +: COORD_W];
        sel_col = bus.req_colour[COL_W*i +: COL_W];
      end
    end
  end

  assign same_pos = (sel_x == sel_ox) && (sel_y == sel_oy);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic: erase is skipped when the sprite has not moved
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (arb_valid) state_next = S_LATCH;
      S_LATCH: state_next = same_pos ? S_DRAW : S_ERASE;
      S_ERASE: if (off == OFF_LAST) state_next = S_DRAW;
      S_DRAW:  if (off == OFF_LAST) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Grant capture, job latches and the pixel offset counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_id_q <= '0;
      grant_mask <= '0;
      off        <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_ox     <= '0;
      lat_oy     <= '0;
      lat_col    <= BLACK;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_valid) begin
            grant_id_q <= arb_idx;
            grant_mask <= arb_grant;
          end
        end
        S_LATCH: begin
          lat_x   <= sel_x;
          lat_y   <= sel_y;
          lat_ox  <= sel_ox;
          lat_oy  <= sel_oy;
          lat_col <= sel_col;
          off     <= '0;
        end
        S_ERASE, S_DRAW: off <= off + OFF_W'(1);
        default: ;
      endcase
    end
  end

  // Output decode for the coming cycle; in LATCH the latches are not loaded
  // yet, so the first pixel comes straight from the selected mover inputs
  always_comb begin
    pix_off = '0;
    base_x  = '0;
    base_y  = '0;
    colour  = BLACK;
    plot_d  = 1'b0;
    x_d     = '0;
    y_d     = '0;
    c_d     = BLACK;
    ack_d   = '0;
    busy_d  = (state_next != S_IDLE);

    if (state_next == S_ACK) ack_d = grant_mask;
    if (state != S_LATCH)    pix_off = off + OFF_W'(1);

    if (state_next == S_ERASE) begin
      base_x = (state == S_LATCH) ? sel_ox : lat_ox;
      base_y = (state == S_LATCH) ? sel_oy : lat_oy;
      colour = bus.bg_colour;
    end else if (state_next == S_DRAW) begin
      base_x = (state == S_LATCH) ? sel_x : lat_x;
      base_y = (state == S_LATCH) ? sel_y : lat_y;
      colour = (state == S_LATCH) ? sel_col : lat_col;
    end

    sum_x = {1'b0, base_x} + {{(SUM_W-SPR_LOG2){1'b0}}, pix_off[SPR_LOG2-1:0]};
    sum_y = {1'b0, base_y} + {{(SUM_W-SPR_LOG2){1'b0}}, pix_off[OFF_W-1:SPR_LOG2]};

    if ((state_next == S_ERASE) || (state_next == S_DRAW)) begin
      x_d    = sum_x[COORD_W-1:0];
      y_d    = sum_y[COORD_W-1:0];
      c_d    = colour;
      plot_d = !sum_x[COORD_W] && !sum_y[COORD_W];
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      plot_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= BLACK;
      ack_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      plot_q <= plot_d;
      x_q    <= x_d;
      y_q    <= y_d;
      c_q    <= c_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
    end
  end

  assign bus.plot     = plot_q;
  assign bus.x_out    = x_q;
  assign bus.y_out    = y_q;
  assign bus.c_out    = c_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;

endmodule
